// File: rtl/led_switch_top.sv
// -----------------------------------------------------------------------------
// led_switch_top
//   Four independent slide-switch debouncers driving four LEDs.
//   Each switch bit is brought into the clk domain through its own
//   SYNC_STAGES-deep flop chain. It is then debounced against an accepted
//   value. A new value is accepted only after it has differed from the
//   accepted value for DEBOUNCE_CYCLES consecutive cycles.
//
// Parameters
//   SYNC_STAGES      synchronizer depth per switch bit (2..4)
//   DEBOUNCE_CYCLES  consecutive mismatch cycles needed to accept (2..65535)
//
// Ports
//   clk    in   1  system clock, all state updates on its rising edge
//   rst_n  in   1  synchronous reset, active HIGH despite the name
//   sw     in   4  asynchronous switch inputs
//   led    out  4  registered LED drive, led[i] = accepted state of sw[i]
// -----------------------------------------------------------------------------
module led_switch_top #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic [3:0] led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      logic                   d_reg;
      logic                   d_next;
      logic [CNT_W-1:0]       cnt_reg;
      logic [CNT_W-1:0]       cnt_next;

      // Synchronizer chain. Bit 0 samples the raw switch input.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      // The counter runs only while the synchronized value disagrees with
      // the accepted one. Any agreement, including the end of a glitch,
      // drops it back to zero. Reaching CNT_MAX accepts the new value and
      // restarts the count, so the counter can never pass CNT_MAX.
      always_comb begin
        d_next   = d_reg;
        cnt_next = '0;
        if (s != d_reg) begin
          if (cnt_reg == CNT_MAX) begin
            d_next = s;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          d_reg   <= 1'b0;
          cnt_reg <= '0;
        end else begin
          d_reg   <= d_next;
          cnt_reg <= cnt_next;
        end
      end

      // The LED is the accepted-value flop itself. No logic sits between it
      // and the pin.
      assign led[gi] = d_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_switch_top.sv
// -----------------------------------------------------------------------------
// tb_led_switch_top
//   Directed scenarios followed by randomized switch activity. Each cycle,
//   the LEDs are compared with a reference model. The model keeps the
//   recent history of synchronized switch values. It flips an accepted bit
//   once the last DEBOUNCE_CYCLES synchronized samples all disagree with it.
// -----------------------------------------------------------------------------
module tb_led_switch_top;

  localparam int S  = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic [3:0] led;

  int vectors     = 0;
  int miscompares = 0;

  led_switch_top #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .led  (led)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [3:0] hist[$];   // the raw samples from the last S edges, oldest first
  logic [3:0] win[$];    // the synchronized values seen at the last DC edges
  logic [3:0] d_m;       // the expected accepted value

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back(4'b0000);
    win.delete();
    d_m = 4'b0000;
  endfunction

  function automatic void model_edge(input logic [3:0] sw_in, input logic rst_in);
    logic [3:0] s_now;
    logic       all_diff;
    if (rst_in) begin
      model_reset();
    end else begin
      s_now = hist.pop_front();
      hist.push_back(sw_in);
      win.push_back(s_now);
      if (win.size() > DC) void'(win.pop_front());
      for (int b = 0; b < 4; b++) begin
        if (win.size() == DC) begin
          all_diff = 1'b1;
          for (int j = 0; j < DC; j++)
            if (win[j][b] == d_m[b]) all_diff = 1'b0;
          if (all_diff) d_m[b] = ~d_m[b];
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    vectors++;
    assert (led === exp) else begin
      miscompares++;
      $error("FAIL %s: led=%b expected=%b", tag, led, exp);
    end
  endtask

  task automatic check_flag(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic [3:0] s_in, input logic r_in);
    @(negedge clk);
    sw    = s_in;
    rst_n = r_in;
    @(posedge clk);
    model_edge(s_in, r_in);
    #1;
    check("model", d_m);
  endtask

  logic [3:0] codes [4];
  logic       saw_high;
  logic [3:0] rv;
  int         hold;

  initial begin
    model_reset();
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b0100; codes[3] = 4'b1000;

    // Reset held with all switches on. Release, then the LEDs go on 6 edges later.
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, 1'b1);
      check("rst_hold", 4'b0000);
    end
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b0);
    check("rst_release_pre", 4'b0000);
    step(4'b1111, 1'b0);
    check("rst_release_rise", 4'b1111);

    // Walking one-hot code.
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 10; k++) step(codes[c], 1'b0);
      check("walk", codes[c]);
    end

    // A 3-cycle pulse is discarded. A 4-cycle pulse is accepted.
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
    check("pulse_base", 4'b0000);
    saw_high = 1'b0;
    for (int k = 0; k < 3; k++) begin step(4'b0001, 1'b0); saw_high |= led[0]; end
    for (int k = 0; k < 10; k++) begin step(4'b0000, 1'b0); saw_high |= led[0]; end
    check_flag("pulse3_ignored", saw_high, 1'b0);
    saw_high = 1'b0;
    for (int k = 0; k < 4; k++) begin step(4'b0001, 1'b0); saw_high |= led[0]; end
    for (int k = 0; k < 10; k++) begin step(4'b0000, 1'b0); saw_high |= led[0]; end
    check_flag("pulse4_accepted", saw_high, 1'b1);

    // sw[2] toggles every cycle, then holds high.
    for (int k = 0; k < 50; k++) step((k % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
    check("toggle_quiet", 4'b0000);
    for (int k = 0; k < 5; k++) step(4'b0100, 1'b0);
    check("toggle_hold_pre", 4'b0000);
    step(4'b0100, 1'b0);
    check("toggle_hold_rise", 4'b0100);

    // Reset in mid-count discards the change. The held value returns after release.
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0101, 1'b0);
    for (int k = 0; k < 2; k++) step(4'b0101, 1'b1);
    check("midcount_reset", 4'b0000);
    for (int k = 0; k < 5; k++) step(4'b0101, 1'b0);
    check("post_reset_pre", 4'b0000);
    step(4'b0101, 1'b0);
    check("post_reset_rise", 4'b0101);

    // All four bits change together.
    for (int k = 0; k < 10; k++) step(4'b0011, 1'b0);
    check("multi_base", 4'b0011);
    for (int k = 0; k < 5; k++) step(4'b1100, 1'b0);
    check("multi_pre", 4'b0011);
    step(4'b1100, 1'b0);
    check("multi_swap", 4'b1100);

    // Random hold lengths straddle the debounce threshold, with occasional resets.
    for (int n = 0; n < 120; n++) begin
      rv   = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < 2; k++) step(rv, 1'b1);
      end else begin
        for (int k = 0; k < hold; k++) step(rv, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_switch_top.md
LED_SWITCH_TOP -- requirements
Module: led_switch_top

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per switch bit; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive cycles a synchronized switch value must differ from the accepted value before it is accepted; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-high (asserted = 1), sampled on the rising edge of clk.
REQ-005 sw  input  4  asynchronous slide-switch inputs, one per bit; no timing relationship to clk.
REQ-006 led  output  4  registered LED drive; led[i] reflects the debounced state of sw[i].

Function
REQ-007 Each sw[i] SHALL pass through its own chain of SYNC_STAGES flops; the last flop output is s[i].
REQ-008 Each bit SHALL hold an accepted value d[i] and a counter cnt[i], with cnt[i] width ceil(log2(DEBOUNCE_CYCLES))+1 bits.
REQ-009 When s[i] == d[i], cnt[i] SHALL be cleared to 0 on the next edge.
REQ-010 When s[i] != d[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-011 When s[i] != d[i] and cnt[i] == DEBOUNCE_CYCLES-1, d[i] SHALL load s[i] and cnt[i] SHALL clear to 0 on the same edge.
REQ-012 A mismatch that ends before acceptance SHALL clear cnt[i]; d[i] is unchanged and the glitch is discarded.
REQ-013 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-014 led[i] SHALL equal d[i] directly from the register, with no combinational path from sw to led.
REQ-015 The four bits SHALL be fully independent; simultaneous changes on several bits are each debounced separately, so bits whose changes are stable for the same duration update on the same edge.
REQ-016 For a change on sw[i] held stable for at least SYNC_STAGES+DEBOUNCE_CYCLES cycles, led[i] SHALL update exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new value. This is 6 edges at the default parameters.
REQ-017 A change on s[i] lasting fewer than DEBOUNCE_CYCLES cycles SHALL NOT alter led[i].

Reset
REQ-018 While rst_n = 1 at a rising edge, the following SHALL all clear to 0 on that edge: every synchronizer flop, every d[i], every cnt[i], and led.
REQ-019 Reset SHALL take priority over every debounce update, including one that would be accepted on the same edge.
REQ-020 Reset asserted mid-count SHALL discard the pending change.
REQ-021 After reset is released, a sw value that is still non-zero SHALL be debounced normally and appear on led per REQ-016.
REQ-022 The outputs are undefined before the first reset edge; there are no initial-value requirements.

Verification (clk period 10 ns)
REQ-023 Hold rst_n = 1 for 10 cycles with sw = 4'b1111 -> led = 4'b0000 throughout reset; after release, led = 4'b1111 exactly 6 edges later.
REQ-024 After reset, step sw through 0001, 0010, 0100, 1000 every 10 cycles -> led follows each value with 6-edge latency and never shows an intermediate value other than those two codes.
REQ-025 With led = 4'b0000, pulse sw[0] high for 3 cycles -> led stays 4'b0000. Pulse it for 4 cycles -> led[0] rises.
REQ-026 Toggle sw[2] every cycle for 50 cycles, then hold it at 1 -> led[2] stays 0 during the toggling and rises 6 edges after the hold begins.
REQ-027 Change sw from 0000 to 0101, then assert rst_n at the 4th edge after the change -> led stays 0000. After release, with sw still 0101, led = 0101 six edges later.
REQ-028 Change sw from 0011 to 1100 on a single edge -> all four led bits update on the same edge, giving 1100 with no intermediate state.
